icache_axi_rd_bridge: RTL and testbench

- Downstream neighbour of the instruction cache: converts the cache's single-line refill request (rd_req/rd_addr, rd_rdy handshake) into one AXI4 read burst.
- Assembles the returned beats into one 128-bit line and hands it back in a single ret_valid pulse.
- Sits between the ICache's AXI-side master port and the SoC AXI interconnect; handles one outstanding refill, read-only.

---
 rtl/icache_axi_rd_bridge.sv | 150 +++++++++++++++
 tb/tb_icache_axi_rd_bridge.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_axi_rd_bridge.sv
// ICache refill bridge: one cache-line request becomes one AXI4 read burst, and the beats are reassembled into a single line return.
// Optional build macro ICACHE_BRIDGE_CRITICAL_WORD_FIRST_EN selects a WRAP burst that starts at the requested word.
module icache_axi_rd_bridge #(
  parameter logic [3:0] AXI_ID = 4'd0,
  parameter int         BEATS  = 4,
  parameter int         LINE_W = BEATS * 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [31:0]       rd_addr,
  output logic              rd_rdy,
  output logic              ret_valid,
  output logic              ret_last,
  output logic [LINE_W-1:0] ret_data,
  output logic              bus_err,
  output logic [3:0]        arid,
  output logic [31:0]       araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = CNT_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       araddr_q, araddr_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_err_q, bus_err_d;

  logic [31:0]       start_addr_s;
  logic [CNT_W-1:0]  start_cnt_s;
  logic [1:0]        burst_s;

`ifdef ICACHE_BRIDGE_CRITICAL_WORD_FIRST_EN
  // Word-aligned WRAP start; the counter begins at the requested word so each beat lands in its line slot.
  assign start_addr_s = {rd_addr[31:2], 2'b00};
  assign start_cnt_s  = rd_addr[OFF_W-1:2];
  assign burst_s      = 2'b10;
  logic unused_addr_bits;
  assign unused_addr_bits = ^rd_addr[1:0];
`else
  assign start_addr_s = {rd_addr[31:OFF_W], {OFF_W{1'b0}}};
  assign start_cnt_s  = {CNT_W{1'b0}};
  assign burst_s      = 2'b01;
  logic unused_addr_bits;
  assign unused_addr_bits = ^rd_addr[OFF_W-1:0];
`endif

  // Next-state, address latch, beat assembly and sticky error logic.
  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    line_d    = line_q;
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          state_d  = AR;
          araddr_d = start_addr_s;
          line_d   = {LINE_W{1'b0}};
          cnt_d    = start_cnt_s;
        end else begin
          state_d  = IDLE;
        end
      end
      AR: begin
        if (arready) begin
          state_d = R;
        end else begin
          state_d = AR;
        end
      end
      R: begin
        if (rvalid) begin
          line_d[{cnt_q, 5'd0} +: 32] = rdata;
          cnt_d = cnt_q + CNT_W'(1);
          if (rresp != 2'b00) begin
            bus_err_d = 1'b1;
          end else begin
            bus_err_d = bus_err_q;
          end
          if (rlast) begin
            state_d = DONE;
          end else begin
            state_d = R;
          end
        end else begin
          state_d = R;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      araddr_q  <= 32'd0;
      line_q    <= {LINE_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      line_q    <= line_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Handshake strobes decode directly from the registered state.
  assign rd_rdy    = (state_q == IDLE);
  assign arvalid   = (state_q == AR);
  assign rready    = (state_q == R);
  assign ret_valid = (state_q == DONE);
  assign ret_last  = ret_valid;
  assign ret_data  = line_q;
  assign bus_err   = bus_err_q;

  assign arid    = AXI_ID;
  assign araddr  = araddr_q;
  assign arlen   = 8'(BEATS - 1);
  assign arsize  = 3'b010;
  assign arburst = burst_s;

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed self-checking bench for icache_axi_rd_bridge; define ICACHE_BRIDGE_CRITICAL_WORD_FIRST_EN to exercise the WRAP build.
module tb_icache_axi_rd_bridge;

  logic         clk;
  logic         rst;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [127:0] ret_data;
  logic         bus_err;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  int checks;
  int errors;

  icache_axi_rd_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_last  (ret_last),
    .ret_data  (ret_data),
    .bus_err   (bus_err),
    .arid      (arid),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Fixed-timeline refill with arready/rvalid high; reports AR-phase fields and the line-return observations.
  task automatic do_refill(input logic [31:0] addr,
                           input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] b2, input logic [31:0] b3,
                           input int nbeats, input int err_idx,
                           output logic [127:0] line, output int pulses,
                           output logic [31:0] ar_addr, output logic [1:0] ar_burst);
    line   = 128'd0;
    pulses = 0;
    next_cycle();
    rd_req = 1'b1; rd_addr = addr; arready = 1'b1;
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    next_cycle();
    rd_req = 1'b0;
    @(negedge clk);
    ar_addr  = araddr;
    ar_burst = arburst;
    next_cycle();
    for (int i = 0; i < nbeats; i++) begin
      rvalid = 1'b1;
      case (i)
        0:       rdata = b0;
        1:       rdata = b1;
        2:       rdata = b2;
        default: rdata = b3;
      endcase
      rresp = (i == err_idx) ? 2'b10 : 2'b00;
      rlast = (i == nbeats - 1);
      next_cycle();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (ret_valid) begin
        pulses++;
        line = ret_data;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL reset_rd_rdy: got %b expected 1", rd_rdy); end
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b expected 0", arvalid); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b expected 0", rready); end
    checks++; if (ret_valid !== 1'b0) begin errors++; $display("FAIL reset_ret_valid: got %b expected 0", ret_valid); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b expected 0", bus_err); end
    checks++; if (ret_data !== 128'd0) begin errors++; $display("FAIL reset_ret_data: got %h expected 0", ret_data); end
    checks++; if (araddr !== 32'd0) begin errors++; $display("FAIL reset_araddr: got %h expected 0", araddr); end
  endtask

  task automatic test_basic_refill();
    next_cycle();
    rd_req = 1'b1; rd_addr = 32'h1FC0_0014; arready = 1'b1; rvalid = 1'b1;
    rdata = 32'h0000_00A0; rlast = 1'b0; rresp = 2'b00;
    @(negedge clk);
    checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL basic_c0_rd_rdy: got %b expected 1", rd_rdy); end
    next_cycle();
    rd_req = 1'b0;
    @(negedge clk);
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL basic_c1_arvalid: got %b expected 1", arvalid); end
    checks++; if (araddr !== 32'h1FC0_0010) begin errors++; $display("FAIL basic_araddr: got %h expected 1fc00010", araddr); end
    checks++; if (arlen !== 8'd3) begin errors++; $display("FAIL basic_arlen: got %0d expected 3", arlen); end
    checks++; if (arsize !== 3'b010) begin errors++; $display("FAIL basic_arsize: got %b expected 010", arsize); end
    checks++; if (arid !== 4'd0) begin errors++; $display("FAIL basic_arid: got %h expected 0", arid); end
    checks++; if (rd_rdy !== 1'b0) begin errors++; $display("FAIL basic_c1_rd_rdy: got %b expected 0", rd_rdy); end
`ifndef ICACHE_BRIDGE_CRITICAL_WORD_FIRST_EN
    checks++; if (arburst !== 2'b01) begin errors++; $display("FAIL basic_arburst: got %b expected 01", arburst); end
`endif
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      rdata = 32'h0000_00A0 + 32'(i);
      rlast = (i == 3);
      @(negedge clk);
      checks++; if (rready !== 1'b1) begin errors++; $display("FAIL basic_rready_c%0d: got %b expected 1", i + 2, rready); end
      checks++; if (ret_valid !== 1'b0) begin errors++; $display("FAIL basic_early_ret_c%0d: got %b expected 0", i + 2, ret_valid); end
    end
    next_cycle();
    rvalid = 1'b0; rlast = 1'b0;
    @(negedge clk);
    checks++; if (ret_valid !== 1'b1) begin errors++; $display("FAIL basic_c6_ret_valid: got %b expected 1", ret_valid); end
    checks++; if (ret_last !== 1'b1) begin errors++; $display("FAIL basic_c6_ret_last: got %b expected 1", ret_last); end
    checks++; if (ret_data !== 128'h000000A3_000000A2_000000A1_000000A0) begin errors++; $display("FAIL basic_ret_data: got %h expected 000000a3000000a2000000a1000000a0", ret_data); end
    checks++; if (rd_rdy !== 1'b0) begin errors++; $display("FAIL basic_c6_rd_rdy: got %b expected 0", rd_rdy); end
    next_cycle();
    @(negedge clk);
    checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL basic_c7_rd_rdy: got %b expected 1", rd_rdy); end
    checks++; if (ret_valid !== 1'b0) begin errors++; $display("FAIL basic_c7_ret_valid: got %b expected 0", ret_valid); end
    checks++; if (ret_data !== 128'h000000A3_000000A2_000000A1_000000A0) begin errors++; $display("FAIL basic_hold_data: got %h expected 000000a3000000a2000000a1000000a0", ret_data); end
  endtask

  task automatic test_stalls();
    int pulses;
    logic [127:0] line;
    pulses = 0;
    line   = 128'd0;
    next_cycle();
    rd_req = 1'b1; rd_addr = 32'h0000_2004; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    for (int j = 0; j < 5; j++) begin
      next_cycle();
      rd_req = 1'b0; rd_addr = 32'hFFFF_FFF0;
      @(negedge clk);
      checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL stall_arvalid_%0d: got %b expected 1", j, arvalid); end
      checks++; if (araddr !== 32'h0000_2000) begin errors++; $display("FAIL stall_araddr_%0d: got %h expected 00002000", j, araddr); end
    end
    next_cycle();
    arready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      arready = 1'b0;
      rvalid  = (k % 2 == 1);
      rdata   = rvalid ? (32'h0000_00C0 + 32'(k / 2)) : 32'hDEAD_BEEF;
      rlast   = (k == 7);
      @(negedge clk);
      checks++; if (ret_valid !== 1'b0) begin errors++; $display("FAIL stall_early_ret_%0d: got %b expected 0", k, ret_valid); end
    end
    next_cycle();
    rvalid = 1'b0; rlast = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (ret_valid) begin
        pulses++;
        line = ret_data;
      end
      next_cycle();
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL stall_pulses: got %0d expected 1", pulses); end
    checks++; if (line !== 128'h000000C3_000000C2_000000C1_000000C0) begin errors++; $display("FAIL stall_line: got %h expected 000000c3000000c2000000c1000000c0", line); end
  endtask

  task automatic test_bus_err();
    int pulses;
    logic [127:0] line;
    logic [31:0] a;
    logic [1:0] b;
    do_refill(32'h0000_3000, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 4, 1, line, pulses, a, b);
    checks++; if (line !== 128'h000000D3_000000D2_000000D1_000000D0) begin errors++; $display("FAIL err_line: got %h expected 000000d3000000d2000000d1000000d0", line); end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", bus_err); end
    do_refill(32'h0000_3010, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 4, -1, line, pulses, a, b);
    checks++; if (line !== 128'h000000E3_000000E2_000000E1_000000E0) begin errors++; $display("FAIL err_clean_line: got %h expected 000000e3000000e2000000e1000000e0", line); end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", bus_err); end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", bus_err); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    logic [127:0] line;
    logic [31:0] a;
    logic [1:0] b;
    next_cycle();
    rd_req = 1'b1; rd_addr = 32'h0000_7000; arready = 1'b1; rvalid = 1'b0; rlast = 1'b0;
    next_cycle();
    rd_req = 1'b0;
    next_cycle();
    rvalid = 1'b1; rdata = 32'h0000_0070;
    next_cycle();
    rdata = 32'h0000_0071;
    next_cycle();
    rst = 1'b1; rvalid = 1'b0;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_rd_rdy: got %b expected 1", rd_rdy); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL rstmid_rready: got %b expected 0", rready); end
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL rstmid_arvalid: got %b expected 0", arvalid); end
    checks++; if (ret_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ret_valid: got %b expected 0", ret_valid); end
    do_refill(32'h0000_0100, 32'h10, 32'h11, 32'h12, 32'h13, 4, -1, line, pulses, a, b);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL rstmid_pulses: got %0d expected 1", pulses); end
    checks++; if (line !== 128'h00000013_00000012_00000011_00000010) begin errors++; $display("FAIL rstmid_line: got %h expected 00000013000000120000001100000010", line); end
    checks++; if (a !== 32'h0000_0100) begin errors++; $display("FAIL rstmid_araddr: got %h expected 00000100", a); end
  endtask

  task automatic test_short_burst();
    int pulses;
    logic [127:0] line;
    logic [31:0] a;
    logic [1:0] b;
    do_refill(32'h0000_4000, 32'hF0, 32'hF1, 32'h0, 32'h0, 2, -1, line, pulses, a, b);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL short_pulses: got %0d expected 1", pulses); end
    checks++; if (line !== 128'h00000000_00000000_000000F1_000000F0) begin errors++; $display("FAIL short_line: got %h expected 0000000000000000000000f1000000f0", line); end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    rd_req = 1'b1; rd_addr = 32'h0000_5000; arready = 1'b1; rvalid = 1'b1;
    rdata = 32'h0000_0050; rlast = 1'b0; rresp = 2'b00;
    next_cycle();
    @(negedge clk);
    checks++; if (araddr !== 32'h0000_5000) begin errors++; $display("FAIL b2b_araddr1: got %h expected 00005000", araddr); end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      rdata = 32'h0000_0050 + 32'(i);
      rlast = (i == 3);
    end
    next_cycle();
    rvalid = 1'b0; rlast = 1'b0; rd_addr = 32'h0000_6000;
    @(negedge clk);
    checks++; if (ret_valid !== 1'b1) begin errors++; $display("FAIL b2b_ret_valid: got %b expected 1", ret_valid); end
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL b2b_done_arvalid: got %b expected 0", arvalid); end
    checks++; if (rd_rdy !== 1'b0) begin errors++; $display("FAIL b2b_done_rd_rdy: got %b expected 0", rd_rdy); end
    next_cycle();
    @(negedge clk);
    checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL b2b_idle_rd_rdy: got %b expected 1", rd_rdy); end
    next_cycle();
    rd_req = 1'b0;
    @(negedge clk);
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL b2b_second_arvalid: got %b expected 1", arvalid); end
    checks++; if (araddr !== 32'h0000_6000) begin errors++; $display("FAIL b2b_araddr2: got %h expected 00006000", araddr); end
    next_cycle();
    rvalid = 1'b1; rdata = 32'h0000_0060; rlast = 1'b1;
    next_cycle();
    rvalid = 1'b0; rlast = 1'b0;
    @(negedge clk);
    checks++; if (ret_valid !== 1'b1) begin errors++; $display("FAIL b2b_ret2_valid: got %b expected 1", ret_valid); end
    checks++; if (ret_data !== 128'h00000000_00000000_00000000_00000060) begin errors++; $display("FAIL b2b_ret2_data: got %h expected 60", ret_data); end
    next_cycle();
  endtask

  task automatic test_start_word();
    int pulses;
    logic [127:0] line;
    logic [31:0] a;
    logic [1:0] b;
`ifdef ICACHE_BRIDGE_CRITICAL_WORD_FIRST_EN
    do_refill(32'h0000_0008, 32'hB2, 32'hB3, 32'hB0, 32'hB1, 4, -1, line, pulses, a, b);
    checks++; if (a !== 32'h0000_0008) begin errors++; $display("FAIL cwf_araddr: got %h expected 00000008", a); end
    checks++; if (b !== 2'b10) begin errors++; $display("FAIL cwf_arburst: got %b expected 10", b); end
`else
    do_refill(32'h0000_0008, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 4, -1, line, pulses, a, b);
    checks++; if (a !== 32'h0000_0000) begin errors++; $display("FAIL incr_araddr: got %h expected 00000000", a); end
    checks++; if (b !== 2'b01) begin errors++; $display("FAIL incr_arburst: got %b expected 01", b); end
`endif
    checks++; if (line !== 128'h000000B3_000000B2_000000B1_000000B0) begin errors++; $display("FAIL start_word_line: got %h expected 000000b3000000b2000000b1000000b0", line); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    rd_req  = 1'b0;
    rd_addr = 32'd0;
    arready = 1'b0;
    rdata   = 32'd0;
    rresp   = 2'b00;
    rlast   = 1'b0;
    rvalid  = 1'b0;
    test_reset();
    test_basic_refill();
    test_stalls();
    test_bus_err();
    test_reset_mid();
    test_short_burst();
    test_back_to_back();
    test_start_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
